// File: rtl/vc_pop_arbiter_pkg.sv
// Shared definitions for the VC pop arbiter: mode encodings, starvation limit
// and the circular first-one search used by the picker.
package vc_pop_arbiter_pkg;
  localparam logic MODE_SP      = 1'b0;
  localparam logic MODE_WRR     = 1'b1;
  localparam int   STARVE_LIMIT = 15;
  localparam int   MAX_VC       = 8;

  typedef struct packed {
    logic       any;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req[0..n-1], scanning circularly from start.
  function automatic pick_t circ_first(input logic [MAX_VC-1:0] req,
                                       input int unsigned n,
                                       input int unsigned start);
    pick_t r;
    int unsigned s, j;
    r = '0;
    s = (start < n) ? start : 0;
    for (int unsigned k = 0; k < MAX_VC; k++) begin
      j = s + k;
      if (j >= n) j = j - n;
      if (k < n && !r.any && req[3'(j)]) begin
        r.any = 1'b1;
        r.idx = 3'(j);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/vc_rr_pick.sv
// Combinational circular priority picker: first requester at or after start_ptr.
module vc_rr_pick
  import vc_pop_arbiter_pkg::*;
#(
  parameter int NUM_VC = 2,
  parameter int SEL_W  = 1
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [SEL_W-1:0]  start_ptr,
  output logic [NUM_VC-1:0] grant_onehot,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any
);
  pick_t             pick;
  logic [MAX_VC-1:0] req_pad;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_VC-1:0]  = req;
    pick                 = circ_first(req_pad, NUM_VC, 32'(start_ptr));
    any                  = pick.any;
    grant_idx            = SEL_W'(pick.idx);
    grant_onehot         = '0;
    if (pick.any) grant_onehot[grant_idx] = 1'b1;
  end
endmodule

// File: rtl/vc_pop_arbiter.sv
// Pops NUM_VC source FIFOs into shared destinations, strict priority or WRR.
// Optional STARVE_GUARD_EN adds starvation override in strict-priority mode.
module vc_pop_arbiter
  import vc_pop_arbiter_pkg::*;
#(
  parameter int NUM_VC   = 2,
  parameter int NUM_DEST = 2,
  parameter int WEIGHT_W = 4,
  parameter int SEL_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         mode,
  input  logic [NUM_VC*WEIGHT_W-1:0]   weights,
  input  logic [NUM_VC-1:0]            VC_empty,
  input  logic [NUM_DEST-1:0]          D_full,
  output logic [NUM_VC-1:0]            VC_rd,
  output logic [SEL_W-1:0]             vc_sel,
  output logic                         rd_valid
);
  logic [NUM_VC-1:0]   eligible, pick_req;
  logic [SEL_W-1:0]    ptr, start_ptr, g;
  logic [WEIGHT_W-1:0] cnt, cnt_n, w_eff;
  logic                any;

  // Any full destination blocks every pop in the same cycle.
  assign eligible = ~VC_empty & {NUM_VC{reset_L & ~(|D_full)}};

`ifdef STARVE_GUARD_EN
  logic [NUM_VC-1:1][7:0] starve_cnt;
  logic [NUM_VC-1:0]      starving;

  always_comb begin
    starving = '0;
    for (int i = 1; i < NUM_VC; i++)
      starving[i] = (mode == MODE_SP) && eligible[i] &&
                    (starve_cnt[i] >= 8'(STARVE_LIMIT));
  end

  // Starving VCs replace the request set; start 0 picks the lowest of them.
  assign pick_req = (|starving) ? starving : eligible;

  always_ff @(posedge clk) begin
    if (!reset_L) starve_cnt <= '0;
    else
      for (int i = 1; i < NUM_VC; i++)
        if (mode == MODE_SP && eligible[i] && !VC_rd[i])
          starve_cnt[i] <= starve_cnt[i] + 8'd1;
        else
          starve_cnt[i] <= '0;
  end
`else
  assign pick_req = eligible;
`endif

  assign start_ptr = (mode == MODE_WRR) ? ptr : '0;

  vc_rr_pick #(.NUM_VC(NUM_VC), .SEL_W(SEL_W)) u_pick (
    .req          (pick_req),
    .start_ptr    (start_ptr),
    .grant_onehot (VC_rd),
    .grant_idx    (g),
    .any          (any)
  );

  always_comb begin
    w_eff = weights[g*WEIGHT_W +: WEIGHT_W];
    if (w_eff == '0) w_eff = WEIGHT_W'(1);
    cnt_n = (g == ptr) ? cnt + WEIGHT_W'(1) : WEIGHT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      vc_sel   <= '0;
      rd_valid <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      rd_valid <= any;
      if (any) vc_sel <= g;
      if (mode == MODE_SP) begin
        ptr <= '0;
        cnt <= '0;
      end else if (any) begin
        if (cnt_n >= w_eff) begin
          ptr <= (g == SEL_W'(NUM_VC-1)) ? '0 : g + 1'b1;
          cnt <= '0;
        end else begin
          ptr <= g;
          cnt <= cnt_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Self-checking bench for vc_pop_arbiter: directed scenarios plus randomized
// traffic against a behavioural grant model.
module tb_vc_pop_arbiter;
  localparam int NV = 2;
  localparam int ND = 2;
  localparam int WW = 4;
  localparam int SW = 1;

  logic             clk = 1'b0;
  logic             reset_L, mode;
  logic [NV*WW-1:0] weights;
  logic [NV-1:0]    VC_empty, VC_rd;
  logic [ND-1:0]    D_full;
  logic [SW-1:0]    vc_sel;
  logic             rd_valid;

  int n_chk = 0;
  int n_fail = 0;
  int m_ptr, m_cnt, m_sel, m_valid;
  int m_starve[NV];

  always #5 clk = ~clk;

  vc_pop_arbiter #(.NUM_VC(NV), .NUM_DEST(ND), .WEIGHT_W(WW)) dut (
    .clk(clk), .reset_L(reset_L), .mode(mode), .weights(weights),
    .VC_empty(VC_empty), .D_full(D_full), .VC_rd(VC_rd),
    .vc_sel(vc_sel), .rd_valid(rd_valid)
  );

  function automatic int wgt(input int i);
    logic [WW-1:0] w;
    w = weights[i*WW +: WW];
    return (w == 0) ? 1 : int'(w);
  endfunction

  function automatic bit elig(input int i);
    return reset_L && !VC_empty[i] && (D_full == '0);
  endfunction

  function automatic int model_grant();
    int start, res;
    res = -1;
    if (reset_L) begin
`ifdef STARVE_GUARD_EN
      if (mode == 1'b0)
        for (int i = NV-1; i >= 1; i--)
          if (elig(i) && m_starve[i] >= 15) res = i;
      if (res >= 0) return res;
`endif
      start = mode ? m_ptr : 0;
      for (int k = NV-1; k >= 0; k--)
        if (elig((start + k) % NV)) res = (start + k) % NV;
    end
    return res;
  endfunction

  task automatic model_update(input int g);
    int c;
    if (!reset_L) begin
      m_ptr = 0; m_cnt = 0; m_sel = 0; m_valid = 0;
      foreach (m_starve[i]) m_starve[i] = 0;
    end else begin
      for (int i = 1; i < NV; i++)
        m_starve[i] = (mode == 1'b0 && elig(i) && g != i) ? m_starve[i] + 1 : 0;
      m_valid = (g >= 0);
      if (g >= 0) m_sel = g;
      if (mode == 1'b0) begin
        m_ptr = 0; m_cnt = 0;
      end else if (g >= 0) begin
        c = (g == m_ptr) ? m_cnt + 1 : 1;
        if (c >= wgt(g)) begin m_ptr = (g + 1) % NV; m_cnt = 0; end
        else begin m_ptr = g; m_cnt = c; end
      end
    end
  endtask

  function automatic logic [NV-1:0] oh(input int g);
    logic [NV-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic post(input int g);
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic test_reset();
    int g;
    reset_L = 1'b0; mode = 1'b0; weights = 8'h13; VC_empty = '0; D_full = '0;
    repeat (4) begin
      @(negedge clk); #1;
      g = model_grant();
      n_chk++;
      if (VC_rd !== 2'b00) begin n_fail++; $display("FAIL reset_rd: got %b expected 00", VC_rd); end
      post(g);
      n_chk++;
      if (vc_sel !== 1'b0 || rd_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_regs: got sel=%b vld=%b expected 0/0", vc_sel, rd_valid);
      end
    end
    @(negedge clk); reset_L = 1'b1; VC_empty = 2'b11; #1;
    g = model_grant();
    n_chk++;
    if (VC_rd !== 2'b00) begin n_fail++; $display("FAIL release_rd: got %b expected 00", VC_rd); end
    post(g);
    n_chk++;
    if (vc_sel !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL release_regs: got sel=%b vld=%b expected 0/0", vc_sel, rd_valid);
    end
  endtask

  task automatic test_strict();
    int g;
    logic [NV-1:0] emp [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [NV-1:0] exp_rd [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); VC_empty = emp[i]; #1;
      g = model_grant();
      n_chk++;
      if (VC_rd !== exp_rd[i]) begin n_fail++; $display("FAIL strict_rd[%0d]: got %b expected %b", i, VC_rd, exp_rd[i]); end
      post(g);
      n_chk++;
      if (rd_valid !== 1'b1 || vc_sel !== exp_rd[i][1]) begin
        n_fail++; $display("FAIL strict_regs[%0d]: got sel=%b vld=%b expected %b/1", i, vc_sel, rd_valid, exp_rd[i][1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g;
    logic [ND-1:0] full [3] = '{2'b10, 2'b01, 2'b11};
    VC_empty = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); D_full = full[i]; #1;
      g = model_grant();
      n_chk++;
      if (VC_rd !== 2'b00) begin n_fail++; $display("FAIL bp_rd[%0d]: got %b expected 00", i, VC_rd); end
      post(g);
      n_chk++;
      if (rd_valid !== 1'b0 || vc_sel !== 1'b1) begin
        n_fail++; $display("FAIL bp_regs[%0d]: got sel=%b vld=%b expected 1/0", i, vc_sel, rd_valid);
      end
    end
    @(negedge clk); D_full = 2'b00; #1;
    g = model_grant();
    n_chk++;
    if (VC_rd !== 2'b01) begin n_fail++; $display("FAIL bp_resume: got %b expected 01", VC_rd); end
    post(g);
  endtask

  task automatic test_wrr();
    int g;
    int seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    @(negedge clk); mode = 1'b0; VC_empty = 2'b11; D_full = '0; #1;
    post(model_grant());
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); mode = 1'b1; weights = 8'h13; VC_empty = 2'b00; #1;
      g = model_grant();
      n_chk++;
      if (VC_rd !== oh(seq[i])) begin n_fail++; $display("FAIL wrr_rd[%0d]: got %b expected %b", i, VC_rd, oh(seq[i])); end
      post(g);
      n_chk++;
      if (rd_valid !== 1'b1 || vc_sel !== SW'(seq[i])) begin
        n_fail++; $display("FAIL wrr_regs[%0d]: got sel=%b vld=%b expected %0d/1", i, vc_sel, rd_valid, seq[i]);
      end
    end
  endtask

  task automatic test_wrr_edge();
    int g;
    int seq [10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1};
    logic [NV-1:0] emp [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    @(negedge clk); mode = 1'b0; VC_empty = 2'b11; #1;
    post(model_grant());
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); mode = 1'b1; weights = 8'h03; VC_empty = emp[i]; #1;
      g = model_grant();
      n_chk++;
      if (VC_rd !== oh(seq[i])) begin n_fail++; $display("FAIL wrr_edge_rd[%0d]: got %b expected %b", i, VC_rd, oh(seq[i])); end
      post(g);
      n_chk++;
      if (rd_valid !== 1'b1 || vc_sel !== SW'(seq[i])) begin
        n_fail++; $display("FAIL wrr_edge_regs[%0d]: got sel=%b vld=%b expected %0d/1", i, vc_sel, rd_valid, seq[i]);
      end
    end
  endtask

`ifdef STARVE_GUARD_EN
  task automatic test_starve();
    int g, e;
    @(negedge clk); reset_L = 1'b0; #1;
    post(model_grant());
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); reset_L = 1'b1; mode = 1'b0; VC_empty = 2'b00; D_full = '0; #1;
      e = (i == 15) ? 1 : 0;
      g = model_grant();
      n_chk++;
      if (VC_rd !== oh(e)) begin n_fail++; $display("FAIL starve_rd[%0d]: got %b expected %b", i, VC_rd, oh(e)); end
      post(g);
    end
  endtask
`endif

  task automatic test_random();
    int g;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) mode = 1'($urandom);
      if ($urandom_range(0, 9) == 0) weights = (NV*WW)'($urandom);
      VC_empty = NV'($urandom);
      D_full   = ($urandom_range(0, 7) == 0) ? ND'($urandom) : '0;
      reset_L  = ($urandom_range(0, 59) != 0);
      #1;
      g = model_grant();
      n_chk++;
      if (VC_rd !== oh(g)) begin n_fail++; $display("FAIL rand_rd[%0d]: got %b expected %b", i, VC_rd, oh(g)); end
      post(g);
      n_chk++;
      if (rd_valid !== 1'(m_valid) || vc_sel !== SW'(m_sel)) begin
        n_fail++; $display("FAIL rand_regs[%0d]: got sel=%b vld=%b expected %0d/%0d", i, vc_sel, rd_valid, m_sel, m_valid);
      end
    end
  endtask

  initial begin
    reset_L = 1'b0; mode = 1'b0; weights = '0; VC_empty = '1; D_full = '0;
    m_ptr = 0; m_cnt = 0; m_sel = 0; m_valid = 0;
    foreach (m_starve[i]) m_starve[i] = 0;
    test_reset();
    test_strict();
    test_backpressure();
    test_wrr();
    test_wrr_edge();
`ifdef STARVE_GUARD_EN
    test_starve();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vc_pop_arbiter.md
Name: vc_pop_arbiter

Overview:
Parametrised pop arbiter that drains NUM_VC virtual-channel FIFOs into shared destination FIFOs. Supports strict-priority (lowest index wins) and weighted-round-robin modes. Any full destination blocks all pops. Generates same-cycle FIFO read strobes plus a registered, one-cycle-delayed selector and valid for the downstream data mux.

Parameters:
NUM_VC, 2, number of virtual-channel source FIFOs (2..8)
NUM_DEST, 2, number of destination FIFOs whose full flags gate popping
WEIGHT_W, 4, width of each per-VC WRR weight
SEL_W, $clog2(NUM_VC) (min 1), width of the selector index

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  synchronous active-low reset
mode  input  1  0 = strict priority, 1 = weighted round robin
weights  input  NUM_VC*WEIGHT_W  per-VC weights; VC i in bits [i*WEIGHT_W +: WEIGHT_W]
VC_empty  input  NUM_VC  per-VC source FIFO empty flags
D_full  input  NUM_DEST  per-destination full flags
VC_rd  output  NUM_VC  one-hot-or-zero combinational read strobes to the VC FIFOs
vc_sel  output  SEL_W  registered index of the VC read in the previous cycle
rd_valid  output  1  registered; 1 when a read occurred in the previous cycle

Behaviour:
- Reset: clk and reset_L (synchronous, active-low). While reset_L=0: VC_rd=0 combinationally. At the next edge: vc_sel=0, rd_valid=0, ptr=0, cnt=0. Reset mid-turn discards WRR state.
- block = OR of D_full. eligible[i] = !VC_empty[i] && !block && reset_L.
- No eligible VC: VC_rd=0. rd_valid<=0. vc_sel, ptr and cnt hold.
- Strict priority (mode=0): grant the lowest-index eligible VC. ptr and cnt are held at 0 every cycle mode=0, so WRR always starts at VC0.
- WRR (mode=1): grant the first eligible VC scanning circularly from ptr (ptr, ptr+1, ..., wrap). Effective weight w_eff[i] = max(weights[i], 1).
  - Grant g == ptr: cnt_n = cnt + 1.
  - Grant g != ptr: turn moves to g, cnt_n = 1.
  - If cnt_n >= w_eff[g]: ptr <= (g+1) mod NUM_VC, cnt <= 0.
  - Otherwise: ptr <= g, cnt <= cnt_n.
  - cnt is WEIGHT_W bits and cannot overflow, because it clears at w_eff.
- Grant: VC_rd[g]=1 in the same cycle, combinational from inputs, flags and state. Next edge: vc_sel <= g, rd_valid <= 1. This gives 1-cycle latency aligned with FIFO read data.
- Full asserting in the same cycle as non-empty: no pop. The block is instantaneous.
- Weights and mode are sampled every cycle. A weight change takes effect on the next comparison.

Optional Feature:
STARVE_GUARD_EN
- Defined, strict-priority mode only: a per-VC starvation counter (8-bit) is added for VC1..NUM_VC-1.
  - The counter increments each cycle its VC is eligible but not granted, and clears on grant, when not eligible, or on reset.
  - When a counter reaches 15, that VC is granted next cycle, overriding priority. The lowest such index wins if several reach 15 at once.
- Undefined: pure strict priority; a lower-priority VC may starve indefinitely. No counters exist.

Decomposition:
- Shared package: mode encodings (MODE_SP=0, MODE_WRR=1), STARVE_LIMIT=15, helper function for circular first-one search.
- One sub-module: vc_rr_pick. Combinational circular priority picker taking (req, start_ptr) and returning (grant_onehot, grant_idx, any). It is instantiated once; strict mode drives start_ptr=0.

Test Plan:
- Reset: hold reset_L=0 with all VCs non-empty and D_full=0 -> VC_rd=0 throughout. After release, next-edge vc_sel=0 and rd_valid=0.
- Strict priority: mode=0, VC_empty=2'b00 -> VC_rd=2'b01 every cycle. Set VC_empty=2'b01 -> VC_rd=2'b10; one cycle later vc_sel=1, rd_valid=1.
- Backpressure: D_full=2'b10 while both VCs non-empty -> VC_rd=0; next cycle rd_valid=0 and vc_sel unchanged. Deassert -> pop resumes the same cycle.
- WRR: NUM_VC=2, weights VC0=3, VC1=1, both always non-empty -> grant sequence 0,0,0,1,0,0,0,1.
- WRR edge cases: weight VC1=0 -> treated as 1. VC0 empty for one cycle mid-turn -> VC1 granted, turn moves to VC1, then ptr wraps to VC0 with cnt=0.
- STARVE_GUARD_EN: mode=0, both VCs non-empty for 20 cycles -> VC0 granted 15 cycles, VC1 granted at cycle 16, counter cleared, then VC0 again.
